tick_timer_bank: RTL

//   Bank of CHANNELS independent programmable tick generators sharing one clock.

---
 rtl/tick_timer_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tick_timer_bank.sv
// Bank of CHANNELS programmable tick generators, each a small IDLE/RUN/DONE FSM
// with a period register. Optional macro TIMER_PRESCALER_EN adds a shared clock divider.
module tick_timer_bank #(
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 60000,
  parameter int PRESCALE       = 1,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [CHANNELS-1:0]   en_i,
  input  logic [CHANNELS-1:0]   oneshot_i,
  input  logic                  wr_i,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [WIDTH-1:0]      wr_period_i,
  output logic [CHANNELS-1:0]   tick_o,
  output logic [CHANNELS-1:0]   busy_o,
  output logic [2*CHANNELS-1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q  [CHANNELS];
  state_e               state_d  [CHANNELS];
  logic [WIDTH-1:0]     cnt_q    [CHANNELS];
  logic [WIDTH-1:0]     cnt_d    [CHANNELS];
  logic [WIDTH-1:0]     period_q [CHANNELS];
  logic [WIDTH-1:0]     period_d [CHANNELS];
  logic [CHANNELS-1:0]  tick_q;
  logic [CHANNELS-1:0]  tick_d;
  logic                 count_en;

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Free-running divider; only reset clears it, channel activity never does.
  always_comb begin
    count_en = (pre_q == PW'(PRESCALE - 1));
    pre_d    = count_en ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) pre_q <= '0;
    else         pre_q <= pre_d;
  end
`else
  assign count_en = 1'b1;
`endif

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch]  = state_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      period_d[ch] = period_q[ch];
      tick_d[ch]   = 1'b0;

      case (state_q[ch])
        ST_IDLE: begin
          cnt_d[ch] = '0;
          if (en_i[ch]) state_d[ch] = ST_RUN;
        end
        ST_RUN: begin
          if (!en_i[ch]) begin
            state_d[ch] = ST_IDLE;
            cnt_d[ch]   = '0;
          end else if (count_en) begin
            if (cnt_q[ch] == period_q[ch]) begin
              cnt_d[ch]  = '0;
              tick_d[ch] = 1'b1;
              if (oneshot_i[ch]) state_d[ch] = ST_DONE;
            end else begin
              cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
          end
        end
        ST_DONE: begin
          cnt_d[ch] = '0;
          if (!en_i[ch]) state_d[ch] = ST_IDLE;
        end
        default: begin
          state_d[ch] = ST_IDLE;
          cnt_d[ch]   = '0;
        end
      endcase

      // A period write overrides the terminal count of the same cycle: no tick,
      // counter restarts, and a one-shot channel does not retire on it.
      if (wr_i && (wr_ch_i == CH_W'(ch))) begin
        period_d[ch] = wr_period_i;
        cnt_d[ch]    = '0;
        tick_d[ch]   = 1'b0;
        if (state_q[ch] == ST_DONE)      state_d[ch] = ST_IDLE;
        else if (state_d[ch] == ST_DONE) state_d[ch] = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= ST_IDLE;
        cnt_q[ch]    <= '0;
        period_q[ch] <= WIDTH'(DEFAULT_PERIOD);
      end
      tick_q <= '0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= state_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
        period_q[ch] <= period_d[ch];
      end
      tick_q <= tick_d;
    end
  end

  always_comb begin
    busy_o      = '0;
    state_dbg_o = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      busy_o[ch]             = (state_q[ch] == ST_RUN);
      state_dbg_o[2*ch +: 2] = state_q[ch];
    end
  end

  assign tick_o = tick_q;

endmodule
